// File: rtl/parity_stream_chk.sv
// parity_stream_chk
// Pipelined parity checker for a valid/ready stream. Each accepted word has
// its parity regenerated in even or odd mode. The word is forwarded through a
// single output register together with the regenerated parity and a per-word
// error flag. A sticky error flag and a saturating error counter record errors.
// Errors are counted at accept time, not at the output handshake.
//
// Configuration macro: PARITY_STREAM_CNT_EN
//   defined     - err_count is a saturating count of errored accepted words
//   not defined - no counter is built and err_count is tied to zero
module parity_stream_chk #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_mode,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_parity,
  output logic             out_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  // Parity of a word: XOR of all bits, inverted in odd mode.
  function automatic logic calc_parity(input logic [N-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // Mismatch between the received parity bit and the regenerated one.
  function automatic logic parity_mismatch(input logic rx_parity, input logic gen_parity);
    return rx_parity ^ gen_parity;
  endfunction

  // Output register state
  logic             out_valid_r;
  logic [N-1:0]     out_data_r;
  logic             out_parity_r;
  logic             out_err_r;
  logic             err_sticky_r;

  // Next-state values
  logic             out_valid_nxt_s;
  logic [N-1:0]     out_data_nxt_s;
  logic             out_parity_nxt_s;
  logic             out_err_nxt_s;
  logic             err_sticky_nxt_s;

  // Handshake and check terms
  logic             gen_parity_s;
  logic             word_err_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             count_err_s;

  // The output slot can take a new word when it is empty or being drained
  // this cycle; the new word then replaces the old one with no bubble.
  assign in_ready_s   = !out_valid_r || out_ready;
  assign accept_s     = in_valid && in_ready_s;
  assign gen_parity_s = calc_parity(in_data, odd_mode);
  assign word_err_s   = parity_mismatch(in_parity, gen_parity_s);
  // An error is recorded only when the word is really accepted and no clear
  // is requested in the same cycle (clear wins).
  assign count_err_s  = accept_s && word_err_s && !clr;

  // Next-state for the output slot and the sticky flag.
  always_comb begin
    out_valid_nxt_s  = out_valid_r;
    out_data_nxt_s   = out_data_r;
    out_parity_nxt_s = out_parity_r;
    out_err_nxt_s    = out_err_r;
    err_sticky_nxt_s = err_sticky_r;

    if (accept_s) begin
      out_valid_nxt_s  = 1'b1;
      out_data_nxt_s   = in_data;
      out_parity_nxt_s = gen_parity_s;
      out_err_nxt_s    = word_err_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_nxt_s  = 1'b0;
    end else begin
      // Slot empty or held under backpressure: everything stays as is.
      out_valid_nxt_s  = out_valid_r;
    end

    if (clr) begin
      err_sticky_nxt_s = 1'b0;
    end else if (count_err_s) begin
      err_sticky_nxt_s = 1'b1;
    end else begin
      err_sticky_nxt_s = err_sticky_r;
    end
  end

  // Output slot and sticky flag registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {N{1'b0}};
      out_parity_r <= 1'b0;
      out_err_r    <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      out_data_r   <= out_data_nxt_s;
      out_parity_r <= out_parity_nxt_s;
      out_err_r    <= out_err_nxt_s;
      err_sticky_r <= err_sticky_nxt_s;
    end
  end

`ifdef PARITY_STREAM_CNT_EN
  // Increment that holds at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == {CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  logic [CNT_W-1:0] err_count_r;
  logic [CNT_W-1:0] err_count_nxt_s;

  // Next error count: clear first, then saturating increment per error.
  always_comb begin
    err_count_nxt_s = err_count_r;
    if (clr) begin
      err_count_nxt_s = {CNT_W{1'b0}};
    end else if (count_err_s) begin
      err_count_nxt_s = sat_inc(err_count_r);
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // Error counter register, updated on the same edge that loads out_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= {CNT_W{1'b0}};
    end else begin
      err_count_r <= err_count_nxt_s;
    end
  end

  assign err_count = err_count_r;
`else
  // Counter not built in this configuration.
  assign err_count = {CNT_W{1'b0}};
`endif

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_parity = out_parity_r;
  assign out_err    = out_err_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_parity_stream_chk.sv
// Testbench for parity_stream_chk. Two instances share one handshake stream:
// A with N=8/CNT_W=8, B with N=4/CNT_W=2 (B sees the low nibble of the data).
// A behavioural model predicts every output and is compared each cycle, and
// directed sequences add literal expectations.
module tb_parity_stream_chk;

`ifdef PARITY_STREAM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int MAX_A = 255;
  localparam int MAX_B = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       odd_mode;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_parity;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_parity, a_out_err, a_err_sticky;
  logic [7:0] a_out_data, a_err_count;
  logic       b_in_ready, b_out_valid, b_out_parity, b_out_err, b_err_sticky;
  logic [3:0] b_out_data;
  logic [1:0] b_err_count;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  parity_stream_chk #(.N(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .clr(clr),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_parity(in_parity), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_parity(a_out_parity), .out_err(a_out_err),
    .err_sticky(a_err_sticky), .err_count(a_err_count)
  );

  parity_stream_chk #(.N(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .clr(clr),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data[3:0]),
    .in_parity(in_parity), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_parity(b_out_parity), .out_err(b_out_err),
    .err_sticky(b_err_sticky), .err_count(b_err_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_valid;
  logic [7:0] ma_data;
  logic [3:0] mb_data;
  logic       ma_par, mb_par, ma_err, mb_err, ma_st, mb_st;
  int         ma_cnt, mb_cnt;
  logic       m_acc, pa, pb;

  assign m_acc = in_valid && (!m_valid || out_ready);
  assign pa = (($countones(in_data) % 2) == 1) ^ odd_mode;
  assign pb = (($countones(in_data[3:0]) % 2) == 1) ^ odd_mode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      ma_data <= 8'h00; mb_data <= 4'h0;
      ma_par <= 1'b0; mb_par <= 1'b0; ma_err <= 1'b0; mb_err <= 1'b0;
      ma_st <= 1'b0; mb_st <= 1'b0; ma_cnt <= 0; mb_cnt <= 0;
    end else begin
      if (m_acc) begin
        m_valid <= 1'b1;
        ma_data <= in_data;      mb_data <= in_data[3:0];
        ma_par  <= pa;           mb_par  <= pb;
        ma_err  <= (in_parity != pa);
        mb_err  <= (in_parity != pb);
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (clr) begin
        ma_st <= 1'b0; mb_st <= 1'b0; ma_cnt <= 0; mb_cnt <= 0;
      end else if (m_acc) begin
        if (in_parity != pa) begin
          ma_st <= 1'b1;
          if (ma_cnt < MAX_A) ma_cnt <= ma_cnt + 1;
        end
        if (in_parity != pb) begin
          mb_st <= 1'b1;
          if (mb_cnt < MAX_B) mb_cnt <= mb_cnt + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      chk("a_out_valid", a_out_valid, m_valid);
      chk("b_out_valid", b_out_valid, m_valid);
      chk("a_in_ready", a_in_ready, (!m_valid || out_ready));
      chk("b_in_ready", b_in_ready, (!m_valid || out_ready));
      if (m_valid) begin
        chk("a_out_data", a_out_data, ma_data);
        chk("a_out_parity", a_out_parity, ma_par);
        chk("a_out_err", a_out_err, ma_err);
        chk("b_out_data", b_out_data, mb_data);
        chk("b_out_parity", b_out_parity, mb_par);
        chk("b_out_err", b_out_err, mb_err);
      end
      chk("a_err_sticky", a_err_sticky, ma_st);
      chk("b_err_sticky", b_err_sticky, mb_st);
      chk("a_err_count", a_err_count, CNT_EN ? ma_cnt : 0);
      chk("b_err_count", b_err_count, CNT_EN ? mb_cnt : 0);
    end
  end

  task automatic reset_check(input string tag);
    chk({tag, "_rst_valid"}, {a_out_valid, b_out_valid}, 2'b00);
    chk({tag, "_rst_ready"}, {a_in_ready, b_in_ready}, 2'b11);
    chk({tag, "_rst_data"}, {a_out_data, b_out_data}, 12'h000);
    chk({tag, "_rst_par_err"}, {a_out_parity, a_out_err, b_out_parity, b_out_err}, 4'b0000);
    chk({tag, "_rst_sticky"}, {a_err_sticky, b_err_sticky}, 2'b00);
    chk({tag, "_rst_count"}, {a_err_count, b_err_count}, 10'h000);
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; odd_mode = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; in_parity = 1'b0; out_ready = 1'b1;
    #1;
    reset_check("init");
    repeat (2) edge_drive();
    rst_n = 1'b1;
    checking = 1'b1;

    // Even mode, back-to-back, out_ready = 1
    in_valid = 1'b1; in_data = 8'h00; in_parity = 1'b0; odd_mode = 1'b0;
    @(negedge clk);
    chk("lat_before_accept", a_out_valid, 1'b0);
    edge_drive(); in_data = 8'h01;
    @(negedge clk);
    chk("even00_data", a_out_data, 8'h00);
    chk("even00_par_err", {a_out_valid, a_out_parity, a_out_err}, 3'b100);
    edge_drive(); in_data = 8'hFF;
    @(negedge clk);
    chk("even01_data", a_out_data, 8'h01);
    chk("even01_err", {a_out_valid, a_out_err}, 2'b11);
    edge_drive(); in_valid = 1'b0;
    @(negedge clk);
    chk("evenFF_data", a_out_data, 8'hFF);
    chk("evenFF_par_err", {a_out_valid, a_out_parity, a_out_err}, 3'b100);
    chk("even_sticky", a_err_sticky, 1'b1);
    chk("even_count", a_err_count, CNT_EN ? 8'd1 : 8'd0);

    // Odd mode on the 4-bit instance
    edge_drive();
    odd_mode = 1'b1; in_valid = 1'b1; in_data = 8'h07; in_parity = 1'b0;
    edge_drive(); in_data = 8'h00;
    @(negedge clk);
    chk("odd0111_par_err", {b_out_valid, b_out_parity, b_out_err}, 3'b100);
    edge_drive(); in_valid = 1'b0;
    @(negedge clk);
    chk("odd0000_par_err", {b_out_valid, b_out_parity, b_out_err}, 3'b111);

    // Backpressure: first word errored, held for three cycles
    edge_drive(); clr = 1'b1;
    edge_drive(); clr = 1'b0;
    odd_mode = 1'b0; in_valid = 1'b1; in_data = 8'h01; in_parity = 1'b0; out_ready = 1'b0;
    edge_drive(); in_data = 8'h02; in_parity = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", a_in_ready, 1'b0);
      chk("bp_data_stable", a_out_data, 8'h01);
      chk("bp_count_once", a_err_count, CNT_EN ? 8'd1 : 8'd0);
    end
    out_ready = 1'b1;
    edge_drive(); in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_word", {a_out_valid, a_out_data, a_out_err}, {1'b1, 8'h02, 1'b0});
    chk("bp_count_after", a_err_count, CNT_EN ? 8'd1 : 8'd0);

    // Saturation: five errored words
    edge_drive(); clr = 1'b1;
    edge_drive(); clr = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; in_parity = 1'b0;
    repeat (5) edge_drive();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_b_count", b_err_count, CNT_EN ? 2'd3 : 2'd0);
    chk("sat_a_count", a_err_count, CNT_EN ? 8'd5 : 8'd0);
    chk("sat_sticky", {a_err_sticky, b_err_sticky}, 2'b11);

    // clr coincident with an errored accept
    edge_drive();
    in_valid = 1'b1; in_data = 8'h01; in_parity = 1'b0; clr = 1'b1;
    edge_drive(); in_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("clr_count", {a_err_count, b_err_count}, 10'h000);
    chk("clr_sticky", {a_err_sticky, b_err_sticky}, 2'b00);
    chk("clr_err_delivered", {a_out_valid, a_out_err, b_out_err}, 3'b111);

    // Randomized stream with occasional mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      edge_drive();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1;
        reset_check("mid");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        in_data   = 8'($urandom);
        in_parity = 1'($urandom);
        if ($urandom_range(0, 15) == 0) odd_mode = ~odd_mode;
        clr       = ($urandom_range(0, 63) == 0);
      end
    end
    edge_drive();
    in_valid = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_stream_chk.md
# parity_stream_chk

Pipelined, parametrised parity checker for a valid/ready data stream. Each accepted word of N bits arrives with a transmitted parity bit. The block recomputes parity in even or odd mode and forwards the word with a per-word error flag and regenerated parity. It also keeps a sticky error flag and a saturating error counter. It sits between a link receiver and downstream consumers, replacing the purely combinational parity checker.

## Interface
- N, default 8: data width in bits, at least 1.
- CNT_W, default 8: error counter width in bits, at least 1.

Ports:
- clk, input, 1: sole clock; rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- odd_mode, input, 1: parity mode. 0 = even, 1 = odd. Sampled with each accepted word.
- clr, input, 1: synchronous clear of err_sticky and err_count.
- in_valid, input, 1: input word valid.
- in_ready, output, 1: block can accept a word.
- in_data, input, N: input word.
- in_parity, input, 1: received parity bit.
- out_valid, output, 1: output word valid.
- out_ready, input, 1: consumer accepts the output word.
- out_data, output, N: forwarded word.
- out_parity, output, 1: regenerated parity for out_data under the sampled mode.
- out_err, output, 1: 1 when in_parity mismatched the regenerated parity.
- err_sticky, output, 1: set on any error, held until clr.
- err_count, output, CNT_W: count of errored words accepted; saturates.

## Operation
- Regenerated parity:
  - even mode: p = XOR of all in_data bits;
  - odd mode: p = NOT of that XOR.
- Error condition: err = (in_parity != p).
- Accept: a word is accepted when in_valid && in_ready on a rising edge.
- in_ready = !out_valid || out_ready. This is a single output register with pass-through backpressure; no combinational path from in_valid to out_valid.
- On accept:
  - out_data, out_parity and out_err load on the next edge;
  - out_valid goes to 1.
- If no accept occurs while out_valid && out_ready, out_valid goes to 0.
- While out_valid && !out_ready, all out_* signals hold stable.
- Error accounting happens at accept time, not at output handshake. On an accepted word with err:
  - err_sticky is set to 1;
  - err_count increments by 1, saturating at 2^CNT_W-1 with no wrap.
- clr has priority over an error in the same cycle: both err_sticky and err_count become 0 and that error is not counted. The data path is unaffected.
- A change of odd_mode affects only words accepted after the change; a held output word keeps its sampled mode.

## Timing
- Reset values while rst_n is low, applied asynchronously:
  - out_valid = 0, out_data = 0, out_parity = 0, out_err = 0;
  - err_sticky = 0, err_count = 0;
  - in_ready = 1, since it follows from out_valid = 0.
- Reset mid-transfer: a held output word is discarded. Counts are lost.
- Release of rst_n is synchronised externally; the first accept may occur on the first edge after release.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word per cycle with out_ready held at 1.
- err_sticky and err_count update on the same edge that loads out_err.
- Simultaneous accept and output handshake: the new word replaces the old one in the same edge with no bubble.

## Configuration
- Macro PARITY_STREAM_CNT_EN.
- Defined: err_count is implemented as described.
- Not defined:
  - the counter is not built and err_count is tied to 0;
  - err_sticky, out_err and the data path are unchanged.

## Test plan
- Reset and idle: assert rst_n = 0 mid-stream, then release. Required: out_valid = 0, in_ready = 1, err_count = 0 and err_sticky = 0 immediately, without waiting for a clock edge.
- Even mode, N = 8, back-to-back words with out_ready = 1:
  - 0x00 with parity 0 → out_err = 0, out_parity = 0;
  - 0x01 with parity 0 → out_err = 1;
  - 0xFF with parity 0 → out_err = 0.
  - Required: err_count = 1, one word per cycle, latency 1.
- Odd mode, N = 4:
  - 4'b0111 with parity 0 → out_err = 0, out_parity = 0;
  - 4'b0000 with parity 0 → out_err = 1, out_parity = 1.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1. Required:
  - in_ready = 0 and out_data stable at its first value;
  - exactly one word is accepted and no error is counted twice;
  - the next word follows on the first cycle after out_ready = 1.
- Saturation with CNT_W = 2: send 5 errored words. Required: err_count = 3 and err_sticky = 1.
- clr coincident with an errored accept. Required: err_count = 0 and err_sticky = 0 on the next cycle, while out_err = 1 is still delivered.
- Rebuild without PARITY_STREAM_CNT_EN. Required: err_count stays 0 throughout while err_sticky still sets.
